// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds and synchronous flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; the default build uses a registered read port.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic [ADDR_W:0]       af_level,
    input  logic [ADDR_W:0]       ae_level,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almostfull  = (count >= af_level);
    assign almostempty = (count <= ae_level);

    assign wr_accept = wr_en && !full && !flush;
    assign rd_accept = rd_en && !empty && !flush;

    // Storage is never reset or flushed; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wr_ack    <= wr_accept;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown continuously; rd_en acknowledges it.
    assign data_out   = mem[rd_ptr];
    assign data_valid = !empty;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
            end
            data_valid <= rd_accept;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Randomised and directed bench for sync_fifo_prog against a queue-based reference model.
module tb_sync_fifo_prog;

    localparam int DW = 16;
    localparam int DEPTH = 8;
    localparam int AW = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [AW:0]   af_level;
    logic [AW:0]   ae_level;
    logic [AW:0]   count;
    logic          full, empty, almostfull, almostempty;
    logic          wr_ack, overflow, underflow;

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(data_out), .data_valid(data_valid),
        .af_level(af_level), .ae_level(ae_level), .count(count),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_out;
    logic          exp_dv, exp_ack, exp_ovf, exp_udf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_out = '0;
        exp_dv  = 1'b0;
        exp_ack = 1'b0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    // One clock edge of FIFO behaviour, in terms of the queue occupancy.
    task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        bit was_full  = (q.size() == DEPTH);
        bit was_empty = (q.size() == 0);
        if (f) begin
            q.delete();
            exp_ack = 1'b0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
            exp_dv  = 1'b0;
        end else begin
            exp_ack = w && !was_full;
            exp_ovf = w && was_full;
            exp_udf = r && was_empty;
            exp_dv  = r && !was_empty;
            if (r && !was_empty) exp_out = q.pop_front();
            if (w && !was_full) q.push_back(d);
        end
    endtask

    task automatic check_all();
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("almostfull", almostfull, q.size() >= int'(af_level));
        chk("almostempty", almostempty, q.size() <= int'(ae_level));
        chk("wr_ack", wr_ack, exp_ack);
        chk("overflow", overflow, exp_ovf);
        chk("underflow", underflow, exp_udf);
`ifdef FIFO_FWFT_EN
        chk("data_valid", data_valid, q.size() != 0);
        if (q.size() != 0) chk("data_out", data_out, q[0]);
`else
        chk("data_valid", data_valid, exp_dv);
        chk("data_out", data_out, exp_out);
`endif
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        wr_en = w; data_in = d; rd_en = r; flush = f;
        @(posedge clk);
        #1;
        model_edge(w, d, r, f);
        check_all();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        af_level = 4'd7; ae_level = 4'd1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        step(1'b1, 16'h0009, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Drain in order, then one rejected read.
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Hold occupancy at 3 with simultaneous traffic; pointers wrap.
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 + DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 16'h0200 + DW'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Threshold walk with a live af_level change.
        ae_level = 4'd2; af_level = 4'd6;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0300 + DW'(i), 1'b0, 1'b0);
        wr_en = 1'b0;
        af_level = 4'd4;
        #1;
        chk("af_live", almostfull, 1'b1);
        for (int i = 5; i < 8; i++) step(1'b1, 16'h0300 + DW'(i), 1'b0, 1'b0);

        // Flush at count 5 beats simultaneous read and write.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'h5555, 1'b1, 1'b1);
        step(1'b1, 16'hABCD, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("flush_rb", data_out, 16'hABCD);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0400 + DW'(i), 1'b0, 1'b0);
        wr_en = 1'b1; data_in = 16'h0404;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
        wr_en = 1'b0;

        // Randomised traffic with occasional flushes and moving thresholds.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                af_level = AW'(0) + (AW + 1)'($urandom_range(0, DEPTH));
                ae_level = (AW + 1)'($urandom_range(0, DEPTH));
            end
            step(1'($urandom_range(0, 99) < 55), DW'($urandom),
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
